// File: rtl/spi_master_arbiter.sv
// Round-robin SPI master sharing one mode-0 bus between NUM_REQ requesters.
// Each grant runs one LSB-first full-duplex word on the winner's chip select.
module spi_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 6,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          busy,
    output logic                          spi_clk,
    output logic                          mosi,
    input  logic                          miso,
    output logic [NUM_REQ-1:0]            cs_n
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TMR_W = $clog2(CLK_DIV + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SCK_HIGH = 3'd2,
        S_SCK_LOW  = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t                  r_state;
    logic [TMR_W-1:0]        r_timer;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [IDX_W-1:0]        r_last;
    logic [DATA_WIDTH-1:0]   r_tx_sr;
    logic [DATA_WIDTH-1:0]   r_rx_sr;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic [NUM_REQ-1:0]      r_ack;
    logic [NUM_REQ-1:0]      r_done;
    logic                    r_busy;
    logic                    r_spi_clk;
    logic                    r_mosi;
    logic [NUM_REQ-1:0]      r_cs_n;

    state_t                  w_state_nxt;
    logic [TMR_W-1:0]        w_timer_nxt;
    logic [BIT_W-1:0]        w_bit_cnt_nxt;
    logic [IDX_W-1:0]        w_last_nxt;
    logic [DATA_WIDTH-1:0]   w_tx_sr_nxt;
    logic [DATA_WIDTH-1:0]   w_rx_sr_nxt;
    logic [DATA_WIDTH-1:0]   w_rx_data_nxt;
    logic [NUM_REQ-1:0]      w_ack_nxt;
    logic [NUM_REQ-1:0]      w_done_nxt;
    logic                    w_busy_nxt;
    logic                    w_spi_clk_nxt;
    logic                    w_mosi_nxt;
    logic [NUM_REQ-1:0]      w_cs_n_nxt;

    logic                    w_found;
    logic [IDX_W-1:0]        w_grant_idx;
    logic [NUM_REQ-1:0]      w_grant_oh;
    logic [NUM_REQ-1:0]      w_last_oh;
    logic [DATA_WIDTH-1:0]   w_tx_word;
    logic [DATA_WIDTH-1:0]   w_rx_shift;
    logic                    w_timer_done;

    assign w_grant_oh   = ONE_HOT0 << w_grant_idx;
    assign w_last_oh    = ONE_HOT0 << r_last;
    assign w_rx_shift   = {miso, r_rx_sr[DATA_WIDTH-1:1]};
    assign w_timer_done = (r_timer == TMR_LAST);

    // Round-robin pick: scanning downward lets the nearest requester after r_last win.
    always_comb begin
        logic [IDX_W-1:0] scan;
        scan        = '0;
        w_grant_idx = r_last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan        = IDX_W'((int'(r_last) + k) % NUM_REQ);
            w_grant_idx = req[scan] ? scan : w_grant_idx;
        end
        w_found = |req;
    end

    // Select the granted requester's transmit word.
    always_comb begin
        w_tx_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_tx_word = w_tx_word |
                (tx_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{IDX_W'(i) == w_grant_idx}});
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_cnt_nxt = r_bit_cnt;
        w_last_nxt    = r_last;
        w_tx_sr_nxt   = r_tx_sr;
        w_rx_sr_nxt   = r_rx_sr;
        w_rx_data_nxt = r_rx_data;
        w_ack_nxt     = '0;
        w_done_nxt    = '0;
        w_busy_nxt    = r_busy;
        w_spi_clk_nxt = r_spi_clk;
        w_mosi_nxt    = r_mosi;
        w_cs_n_nxt    = r_cs_n;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = S_SETUP;
                    w_timer_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_last_nxt    = w_grant_idx;
                    w_tx_sr_nxt   = {1'b0, w_tx_word[DATA_WIDTH-1:1]};
                    w_mosi_nxt    = w_tx_word[0];
                    w_ack_nxt     = w_grant_oh;
                    w_cs_n_nxt    = ~w_grant_oh;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_busy_nxt    = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_timer_done) begin
                    w_state_nxt   = S_SCK_HIGH;
                    w_timer_nxt   = '0;
                    w_spi_clk_nxt = 1'b1;
                    w_rx_sr_nxt   = w_rx_shift;
                end else begin
                    w_timer_nxt   = r_timer + TMR_W'(1);
                end
            end
            S_SCK_HIGH: begin
                if (w_timer_done) begin
                    w_state_nxt   = S_SCK_LOW;
                    w_timer_nxt   = '0;
                    w_spi_clk_nxt = 1'b0;
                    if (r_bit_cnt != BIT_LAST) begin
                        w_mosi_nxt  = r_tx_sr[0];
                        w_tx_sr_nxt = {1'b0, r_tx_sr[DATA_WIDTH-1:1]};
                    end else begin
                        w_mosi_nxt  = r_mosi;
                    end
                end else begin
                    w_timer_nxt   = r_timer + TMR_W'(1);
                end
            end
            S_SCK_LOW: begin
                if (w_timer_done) begin
                    w_timer_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt   = S_GAP;
                        w_cs_n_nxt    = '1;
                        w_done_nxt    = w_last_oh;
                        w_rx_data_nxt = r_rx_sr;
                        w_mosi_nxt    = 1'b0;
                    end else begin
                        w_state_nxt   = S_SCK_HIGH;
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                        w_spi_clk_nxt = 1'b1;
                        w_rx_sr_nxt   = w_rx_shift;
                    end
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (w_timer_done) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_timer_nxt   = '0;
                w_busy_nxt    = 1'b0;
                w_spi_clk_nxt = 1'b0;
                w_mosi_nxt    = 1'b0;
                w_cs_n_nxt    = '1;
            end
        endcase
    end

    // State and registered-output update; reset releases the bus at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_spi_clk <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_last    <= w_last_nxt;
            r_tx_sr   <= w_tx_sr_nxt;
            r_rx_sr   <= w_rx_sr_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_ack     <= w_ack_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_spi_clk <= w_spi_clk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
        end
    end

    assign ack     = r_ack;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign spi_clk = r_spi_clk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: vector table plus multi-cycle sequences, with a
// done-side scoreboard fed at each ack and a second 4-requester, CLK_DIV=1 instance.
module tb_spi_master_arbiter;

    typedef struct {
        int         idx;
        logic [5:0] tx;
        logic [5:0] rx;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [5:0] tx0;
        logic [5:0] tx1;
        logic [5:0] pat;
        int         grant;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [11:0] tx_data;
    logic [1:0]  d_ack, d_done, d_cs_n;
    logic [5:0]  d_rx_data;
    logic        d_busy, d_spi_clk, d_mosi;
    logic        d_miso = 1'b0;

    logic [3:0]  req4;
    logic [23:0] tx_data4 = 24'h5A5A5A;
    logic [3:0]  d_ack4, d_done4, d_cs_n4;
    logic [5:0]  d_rx4;
    logic        d_busy4, d_sck4, d_mosi4;
    logic        miso4 = 1'b1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    logic [5:0] cur_pat = 6'd0;
    int   done_cnt = 0;
    int   ack1_cnt = 0;
    int   cs_viol  = 0;

    spi_master_arbiter #(.NUM_REQ(2), .DATA_WIDTH(6), .CLK_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .tx_data(tx_data),
        .ack(d_ack), .done(d_done), .rx_data(d_rx_data), .busy(d_busy),
        .spi_clk(d_spi_clk), .mosi(d_mosi), .miso(d_miso), .cs_n(d_cs_n)
    );

    spi_master_arbiter #(.NUM_REQ(4), .DATA_WIDTH(6), .CLK_DIV(1)) u_dut4 (
        .clk(clk), .reset(reset), .req(req4), .tx_data(tx_data4),
        .ack(d_ack4), .done(d_done4), .rx_data(d_rx4), .busy(d_busy4),
        .spi_clk(d_sck4), .mosi(d_mosi4), .miso(miso4), .cs_n(d_cs_n4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave model and done-side scoreboard for the 2-requester instance.
    initial begin
        logic [2:0] rise_cnt;
        logic [5:0] mosi_cap;
        logic       prev_sck;
        logic [1:0] oh;
        exp_t       e;
        rise_cnt = 3'd0;
        mosi_cap = 6'd0;
        prev_sck = 1'b0;
        forever begin
            @(negedge clk);
            if (d_spi_clk && !prev_sck && rise_cnt < 3'd6) begin
                mosi_cap[rise_cnt] = d_mosi;
                rise_cnt = rise_cnt + 3'd1;
            end
            prev_sck = d_spi_clk;
            if (d_ack[1]) ack1_cnt++;
            if (d_cs_n == 2'b00) cs_viol++;
            if (d_done != 2'b00) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {30'd0, d_done}, 32'd0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = 2'b01 << e.idx;
                    check("done_onehot", {30'd0, d_done}, {30'd0, oh});
                    check("rx_data", {26'd0, d_rx_data}, {26'd0, e.rx});
                    check("mosi_word", {26'd0, mosi_cap}, {26'd0, e.tx});
                end
            end
            if (d_cs_n == 2'b11) rise_cnt = 3'd0;
            d_miso = (rise_cnt < 3'd6) ? cur_pat[rise_cnt] : 1'b0;
        end
    end

    task automatic wait_ack(input int idx, input logic [5:0] tx, input logic [5:0] rx, output int t_ack);
        int         n;
        logic [1:0] oh;
        logic [1:0] ncs;
        exp_t       e;
        n   = 0;
        oh  = 2'b01 << idx;
        ncs = ~oh;
        do begin
            @(negedge clk);
            n++;
        end while (d_ack == 2'b00 && n < 40);
        t_ack = cyc;
        check("ack", {30'd0, d_ack}, {30'd0, oh});
        check("cs_n_at_ack", {30'd0, d_cs_n}, {30'd0, ncs});
        check("busy_at_ack", {31'd0, d_busy}, 32'd1);
        if (d_ack != 2'b00) begin
            e.idx = idx;
            e.tx  = tx;
            e.rx  = rx;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int t_ack, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_done == 2'b00 && n < 60);
        check("done_latency", cyc - t_ack, lat);
        check("busy_in_gap", {31'd0, d_busy}, 32'd1);
        check("cs_released", {30'd0, d_cs_n}, 32'd3);
        repeat (2) @(negedge clk);
        check("busy_idle", {31'd0, d_busy}, 32'd0);
    endtask

    initial begin
        vec_t       vecs [6];
        int         t, t_prev, g, a1, dcnt, n, r1, r2;
        logic       prev4;
        logic [5:0] exp_tx, tx0, tx1;

        vecs[0] = '{2'b01, 6'b101101, 6'b000000, 6'b010011, 0};
        vecs[1] = '{2'b10, 6'b000000, 6'b110010, 6'b101010, 1};
        vecs[2] = '{2'b10, 6'b111111, 6'b000111, 6'b111000, 1};
        vecs[3] = '{2'b11, 6'b011110, 6'b100001, 6'b001100, 0};
        vecs[4] = '{2'b11, 6'b011110, 6'b100001, 6'b110011, 1};
        vecs[5] = '{2'b01, 6'b111111, 6'b010101, 6'b000000, 0};

        reset   = 1'b0;
        req     = 2'b00;
        req4    = 4'b0000;
        tx_data = 12'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ack",     {30'd0, d_ack},     32'd0);
        check("rst_done",    {30'd0, d_done},    32'd0);
        check("rst_busy",    {31'd0, d_busy},    32'd0);
        check("rst_cs_n",    {30'd0, d_cs_n},    32'd3);
        check("rst_spi_clk", {31'd0, d_spi_clk}, 32'd0);
        check("rst_mosi",    {31'd0, d_mosi},    32'd0);
        check("rst_rx_data", {26'd0, d_rx_data}, 32'd0);
        check("rst_cs_n4",   {28'd0, d_cs_n4},   32'd15);

        foreach (vecs[v]) begin
            cur_pat = vecs[v].pat;
            tx_data = {vecs[v].tx1, vecs[v].tx0};
            req     = vecs[v].req;
            exp_tx  = (vecs[v].grant == 0) ? vecs[v].tx0 : vecs[v].tx1;
            wait_ack(vecs[v].grant, exp_tx, vecs[v].pat, t);
            req     = 2'b00;
            tx_data = ~tx_data;
            wait_done(t, 26);
        end

        // Asynchronous reset in the middle of bit 3.
        cur_pat = 6'b100110;
        tx_data = {6'd0, 6'b110011};
        req     = 2'b01;
        wait_ack(0, 6'b110011, 6'b100110, t);
        req = 2'b00;
        repeat (14) @(negedge clk);
        check("mid_bit3_sck", {31'd0, d_spi_clk}, 32'd1);
        dcnt = done_cnt;
        #2 reset = 1'b0;
        #1;
        check("abort_cs_n",    {30'd0, d_cs_n},    32'd3);
        check("abort_spi_clk", {31'd0, d_spi_clk}, 32'd0);
        check("abort_busy",    {31'd0, d_busy},    32'd0);
        @(negedge clk);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("no_done_after_abort", done_cnt, dcnt);

        // Both requesters held: alternation from requester 0, 29-cycle spacing.
        tx0     = 6'b110100;
        tx1     = 6'b001011;
        cur_pat = 6'b011001;
        tx_data = {tx1, tx0};
        req     = 2'b11;
        wait_ack(0, tx0, cur_pat, t_prev);
        for (int i = 1; i < 4; i++) begin
            g = i % 2;
            wait_ack(g, (g == 1) ? tx1 : tx0, cur_pat, t);
            check("ack_spacing", t - t_prev, 29);
            t_prev = t;
        end
        req = 2'b00;
        repeat (32) @(negedge clk);
        check("cs_exclusive", cs_viol, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        // One-cycle request pulse while busy is never acknowledged.
        cur_pat = 6'b111010;
        tx_data = {6'b010101, 6'b100011};
        req     = 2'b01;
        wait_ack(0, 6'b100011, 6'b111010, t);
        req = 2'b00;
        a1  = ack1_cnt;
        repeat (3) @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        repeat (30) @(negedge clk);
        check("pulsed_req_ignored", ack1_cnt, a1);
        req = 2'b10;
        wait_ack(1, 6'b010101, 6'b111010, t);
        req = 2'b00;
        wait_done(t, 26);

        // Four requesters, CLK_DIV=1, miso held high.
        req4 = 4'b1010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_ack4 == 4'b0000 && n < 20);
        t = cyc;
        check("dut4_first_ack", {28'd0, d_ack4}, 32'd2);
        r1 = -1;
        r2 = -1;
        prev4 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (d_sck4 && !prev4) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev4 = d_sck4;
        end while (d_done4 == 4'b0000 && n < 40);
        check("dut4_sck_period", r2 - r1, 2);
        check("dut4_latency", cyc - t, 13);
        check("dut4_done", {28'd0, d_done4}, 32'd2);
        check("dut4_rx", {26'd0, d_rx4}, 32'h3F);
        t_prev = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_ack4 == 4'b0000 && n < 20);
        check("dut4_second_ack", {28'd0, d_ack4}, 32'd8);
        check("dut4_ack_spacing", cyc - t_prev, 15);
        req4 = 4'b0000;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
